// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch-side instruction/handshake, writeback port, EX hazard
// inputs, and the decoded operands going to execute.
interface decode_stage_if #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32
);
    logic [INSTR_LEN-1:0] instruction;
    logic [WORD-1:0]      pc_in;
    logic                 instr_valid;
    logic                 stall;
    logic                 flush;
    logic                 wb_en;
    logic [4:0]           wb_addr;
    logic [WORD-1:0]      wb_data;
    logic                 ex_mem_read;
    logic [4:0]           ex_rd;

    logic [WORD-1:0]      pc_out;
    logic [10:0]          opcode;
    logic [4:0]           rd_addr;
    logic [WORD-1:0]      rd1;
    logic [WORD-1:0]      rd2;
    logic [WORD-1:0]      imm;
    logic                 valid_out;
    logic                 load_use_stall;

    modport master (
        output instruction, pc_in, instr_valid, stall, flush,
               wb_en, wb_addr, wb_data, ex_mem_read, ex_rd,
        input  pc_out, opcode, rd_addr, rd1, rd2, imm, valid_out, load_use_stall
    );

    modport slave (
        input  instruction, pc_in, instr_valid, stall, flush,
               wb_en, wb_addr, wb_data, ex_mem_read, ex_rd,
        output pc_out, opcode, rd_addr, rd1, rd2, imm, valid_out, load_use_stall
    );
endinterface

// File: rtl/decode_stage.sv
// ARMv8-style decode stage: IF/ID latch, XZR-aware register file with
// write-through bypass, immediate extraction and load-use hazard detection.
module decode_stage #(
    parameter int WORD      = 64,
    parameter int INSTR_LEN = 32,
    parameter int NREGS     = 32
) (
    input  logic         clk,
    input  logic         reset,
    decode_stage_if.slave dif
);
    localparam logic [4:0] XZR = 5'd31;

    logic [INSTR_LEN-1:0] instr_q, instr_d;
    logic [WORD-1:0]      pc_q, pc_d;
    logic                 valid_q, valid_d;
    logic [WORD-1:0]      regs_q [NREGS];

    // Flush beats stall beats load.
    // NOTE: always_comb assigns every output a default first so no path can infer a latch.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (dif.flush) begin
            instr_d = '0;
            pc_d    = '0;
            valid_d = 1'b0;
        end else if (!dif.stall) begin
            instr_d = dif.instruction;
            pc_d    = dif.pc_in;
            valid_d = dif.instr_valid;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    // NOTE: the register file is cleared by reset because architectural state must read 0 after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (dif.wb_en && dif.wb_addr != XZR) begin
            regs_q[dif.wb_addr] <= dif.wb_data;
        end
    end

    logic [4:0]  rn_idx, reg2_idx;
    logic [10:0] op;

    assign op       = instr_q[31:21];
    assign rn_idx   = instr_q[9:5];
    assign reg2_idx = instr_q[28] ? instr_q[4:0] : instr_q[20:16];

    // Bypass is gated by reset so a writeback presented during reset never leaks out.
    function automatic logic [WORD-1:0] read_reg(input logic [4:0] idx);
        if (idx == XZR)                                 return '0;
        else if (!reset && dif.wb_en && dif.wb_addr == idx) return dif.wb_data;
        else                                            return regs_q[idx];
    endfunction

    logic [WORD-1:0] imm_c;

    always_comb begin
        imm_c = '0;
        if (op[10:5] == 6'b000101)
            imm_c = {{(WORD-26){instr_q[25]}}, instr_q[25:0]};
        else if (op[10:4] == 7'b1011010)
            imm_c = {{(WORD-19){instr_q[23]}}, instr_q[23:5]};
        else if (op == 11'b11111000000 || op == 11'b11111000010)
            imm_c = {{(WORD-9){instr_q[20]}}, instr_q[20:12]};
        else if (op[10:1] == 10'b1001000100 || op[10:1] == 10'b1101000100)
            imm_c = {{(WORD-12){1'b0}}, instr_q[21:10]};
    end

    assign dif.pc_out         = pc_q;
    assign dif.opcode         = op;
    assign dif.rd_addr        = instr_q[4:0];
    assign dif.rd1            = read_reg(rn_idx);
    assign dif.rd2            = read_reg(reg2_idx);
    assign dif.imm            = imm_c;
    assign dif.valid_out      = valid_q;
    assign dif.load_use_stall = valid_q && dif.ex_mem_read && (dif.ex_rd != XZR) &&
                                (dif.ex_rd == rn_idx || dif.ex_rd == reg2_idx);
endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: reset, writeback/bypass,
// immediates, stall/flush priority, load-use hazard and reg2 selection.
module tb_decode_stage;
    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    localparam logic [31:0] ADD_X1_X2_X3  = 32'h8B03_0041;
    localparam logic [31:0] ADD_X1_X31_X3 = 32'h8B03_03E1;
    localparam logic [31:0] ADD_X1_X5_X3  = 32'h8B03_00A1;
    localparam logic [31:0] LDUR_X5_M1    = 32'hF85F_F045;
    localparam logic [31:0] ADDI_FFF      = 32'h913F_FC41;
    localparam logic [31:0] B_NEG         = 32'h1600_0000;
    localparam logic [31:0] CBZ_NEG       = 32'hB480_0000;
    localparam logic [31:0] CBNZ_5        = 32'hB500_00A0;
    localparam logic [31:0] STUR_X7_X2    = 32'hF800_0047;

    decode_stage_if #(.WORD(64), .INSTR_LEN(32)) dif ();

    decode_stage #(.WORD(64), .INSTR_LEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [63:0] pc, input logic v);
        dif.instruction = ins;
        dif.pc_in       = pc;
        dif.instr_valid = v;
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [63:0] d);
        dif.wb_en   = en;
        dif.wb_addr = a;
        dif.wb_data = d;
    endtask

    initial begin
        reset = 1'b1;
        fetch(32'h0, 64'h0, 1'b0);
        dif.stall = 1'b0;
        dif.flush = 1'b0;
        wb(1'b0, 5'd0, 64'h0);
        dif.ex_mem_read = 1'b0;
        dif.ex_rd = 5'd0;
        tick(); tick();
        check("reset_pc", dif.pc_out, 64'h0);
        check("reset_valid", {63'h0, dif.valid_out}, 64'h0);
        check("reset_rd1", dif.rd1, 64'h0);
        reset = 1'b0;

        // Write X2, latch ADD X1,X2,X3; then bypass X3 in the same cycle.
        wb(1'b1, 5'd2, 64'h22);
        fetch(ADD_X1_X2_X3, 64'h100, 1'b1);
        tick();
        wb(1'b1, 5'd3, 64'h1234);
        #1;
        check("bypass_rd2", dif.rd2, 64'h1234);
        check("add_rd1", dif.rd1, 64'h22);
        check("add_opcode", {53'h0, dif.opcode}, 64'h458);
        check("add_rd_addr", {59'h0, dif.rd_addr}, 64'h1);
        check("add_pc", dif.pc_out, 64'h100);
        check("add_imm_zero", dif.imm, 64'h0);
        tick();
        wb(1'b0, 5'd0, 64'h0);
        #1;
        check("x3_stored", dif.rd2, 64'h1234);

        // Load-use hazard with ADD X1,X2,X3 latched.
        dif.ex_mem_read = 1'b1;
        dif.ex_rd = 5'd2; #1;
        check("lu_rn", {63'h0, dif.load_use_stall}, 64'h1);
        dif.ex_rd = 5'd3; #1;
        check("lu_rm", {63'h0, dif.load_use_stall}, 64'h1);
        dif.ex_rd = 5'd4; #1;
        check("lu_other", {63'h0, dif.load_use_stall}, 64'h0);
        dif.ex_rd = 5'd31; #1;
        check("lu_xzr", {63'h0, dif.load_use_stall}, 64'h0);
        dif.ex_mem_read = 1'b0;
        dif.ex_rd = 5'd2; #1;
        check("lu_no_load", {63'h0, dif.load_use_stall}, 64'h0);

        // XZR: write of 0xFF ignored, bypass suppressed.
        wb(1'b1, 5'd31, 64'hFF);
        fetch(ADD_X1_X31_X3, 64'h104, 1'b1);
        tick();
        check("xzr_bypass", dif.rd1, 64'h0);
        tick();
        wb(1'b0, 5'd0, 64'h0);
        #1;
        check("xzr_read", dif.rd1, 64'h0);

        // valid_out=0 masks the hazard.
        fetch(ADD_X1_X2_X3, 64'h108, 1'b0);
        dif.ex_mem_read = 1'b1;
        dif.ex_rd = 5'd2;
        tick();
        check("invalid_valid", {63'h0, dif.valid_out}, 64'h0);
        check("lu_invalid", {63'h0, dif.load_use_stall}, 64'h0);
        dif.ex_mem_read = 1'b0;

        // Immediates.
        fetch(LDUR_X5_M1, 64'h10C, 1'b1); tick();
        check("imm_ldur", dif.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        fetch(ADDI_FFF, 64'h110, 1'b1); tick();
        check("imm_addi", dif.imm, 64'h0000_0000_0000_0FFF);
        fetch(B_NEG, 64'h114, 1'b1); tick();
        check("imm_b", dif.imm, 64'hFFFF_FFFF_FE00_0000);
        fetch(CBZ_NEG, 64'h118, 1'b1); tick();
        check("imm_cbz", dif.imm, 64'hFFFF_FFFF_FFFC_0000);
        fetch(CBNZ_5, 64'h11C, 1'b1); tick();
        check("imm_cbnz", dif.imm, 64'h5);

        // Reg2 select: STUR uses Rt (X7), not Rm (X0).
        wb(1'b1, 5'd7, 64'h77); tick();
        wb(1'b1, 5'd0, 64'hAA); tick();
        wb(1'b0, 5'd0, 64'h0);
        fetch(STUR_X7_X2, 64'h120, 1'b1); tick();
        check("stur_rd2", dif.rd2, 64'h77);
        check("stur_rd1", dif.rd1, 64'h22);
        check("stur_imm", dif.imm, 64'h0);

        // Stall holds for 3 cycles, flush overrides stall.
        fetch(ADD_X1_X2_X3, 64'h200, 1'b1); tick();
        check("pre_stall_pc", dif.pc_out, 64'h200);
        fetch(LDUR_X5_M1, 64'h300, 1'b1);
        dif.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_pc_%0d", i), dif.pc_out, 64'h200);
        end
        check("stall_opcode", {53'h0, dif.opcode}, 64'h458);
        dif.flush = 1'b1;
        tick();
        check("flush_valid", {63'h0, dif.valid_out}, 64'h0);
        check("flush_pc", dif.pc_out, 64'h0);
        check("flush_opcode", {53'h0, dif.opcode}, 64'h0);
        dif.flush = 1'b0;
        dif.stall = 1'b0;
        tick();
        check("resume_pc", dif.pc_out, 64'h300);
        check("resume_valid", {63'h0, dif.valid_out}, 64'h1);

        // Mid-run reset with a pending writeback to X5.
        wb(1'b1, 5'd5, 64'h55); tick();
        fetch(ADD_X1_X5_X3, 64'h400, 1'b1);
        wb(1'b0, 5'd0, 64'h0);
        tick();
        check("x5_before_reset", dif.rd1, 64'h55);
        dif.ex_mem_read = 1'b1;
        dif.ex_rd = 5'd5;
        #1;
        wb(1'b1, 5'd5, 64'h99);
        reset = 1'b1;
        #1;
        check("async_pc", dif.pc_out, 64'h0);
        check("async_valid", {63'h0, dif.valid_out}, 64'h0);
        check("async_opcode", {53'h0, dif.opcode}, 64'h0);
        check("async_rd1", dif.rd1, 64'h0);
        check("async_rd2", dif.rd2, 64'h0);
        check("async_imm", dif.imm, 64'h0);
        check("async_lu", {63'h0, dif.load_use_stall}, 64'h0);
        tick();
        wb(1'b0, 5'd0, 64'h0);
        dif.ex_mem_read = 1'b0;
        reset = 1'b0;
        fetch(ADD_X1_X5_X3, 64'h500, 1'b1);
        tick();
        check("post_reset_pc", dif.pc_out, 64'h500);
        check("post_reset_x5", dif.rd1, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter WORD, default 64: data/address width.
REQ-002 SHALL have parameter INSTR_LEN, default 32: instruction width.
REQ-003 SHALL have parameter NREGS, default 32: register count; index 31 is XZR.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 instruction  in  INSTR_LEN  fetched instruction.
REQ-007 pc_in  in  WORD  PC of that instruction.
REQ-008 instr_valid  in  1  fetch output valid.
REQ-009 stall  in  1  hold the IF/ID latch.
REQ-010 flush  in  1  squash the IF/ID latch (taken branch).
REQ-011 wb_en, wb_addr, wb_data  in  1/5/WORD  writeback port.
REQ-012 ex_mem_read, ex_rd  in  1/5  EX-stage load flag and destination.
REQ-013 pc_out  out  WORD  latched PC.
REQ-014 opcode  out  11  latched instruction[31:21].
REQ-015 rd_addr  out  5  latched instruction[4:0].
REQ-016 rd1, rd2  out  WORD  register operands.
REQ-017 imm  out  WORD  extended immediate.
REQ-018 valid_out  out  1  latched instruction is live.
REQ-019 load_use_stall  out  1  hazard request to fetch and this stage.

Function
REQ-020 IF/ID latch SHALL, on each rising edge, apply priority flush > stall > load.
- flush: instr=0, pc=0, valid=0.
- stall (no flush): hold all latched values.
- otherwise: capture instruction, pc_in, instr_valid.
REQ-021 Decode outputs SHALL be combinational from latched state; latency is 1 cycle from fetch output to decode outputs.
REQ-022 Field extraction SHALL be: Rn=[9:5], Rm=[20:16], Rt=[4:0]; reg2 index = Rt when latched bit[28]=1, else Rm.
REQ-023 Register file SHALL be NREGS x WORD with one synchronous write port and two combinational read ports.
REQ-024 Reads of index 31 SHALL return 0; writes to index 31 SHALL be ignored.
REQ-025 When wb_en=1 and wb_addr equals a read index other than 31, that read SHALL return wb_data in the same cycle (write-through bypass).
REQ-026 imm SHALL be selected by latched opcode:
- B (op[10:5]=000101): sign-extend [25:0].
- CB (op[10:3]=1011010x): sign-extend [23:5].
- D (op=11111000000 or 11111000010): sign-extend [20:12].
- I (op[10:1]=1001000100 or 1101000100): zero-extend [21:10].
- any other opcode: 0.
REQ-027 load_use_stall SHALL equal valid_out & ex_mem_read & (ex_rd!=31) & (ex_rd==Rn | ex_rd==reg2 index); it is combinational.
REQ-028 When valid_out=0, load_use_stall SHALL be 0; the other outputs are don't-care but SHALL be deterministic.
REQ-029 Register writes SHALL proceed regardless of stall or flush.

Reset
REQ-030 While reset=1, independent of clk:
- latched instr, pc and valid_out SHALL be 0;
- all registers SHALL be 0;
- consequently pc_out=0, opcode=0, rd1=rd2=imm=0 and load_use_stall=0.
REQ-031 Reset asserted mid-operation SHALL discard any pending writeback in that cycle.
REQ-032 On the first rising edge after reset deasserts, normal capture SHALL resume.

Verification
REQ-033 Reset: assert reset mid-run -> all outputs 0 immediately, before any clock edge; X5 reads 0 afterwards.
REQ-034 Writeback and bypass: wb X3=0x1234 with ADD X1,X2,X3 latched -> rd2=0x1234 in the same cycle; X31 write of 0xFF -> reads 0.
REQ-035 Immediate extraction:
- LDUR with imm9=0x1FF -> imm=0xFFFF_FFFF_FFFF_FFFF.
- ADDI with imm12=0xFFF -> imm=0xFFF.
- B with imm26=0x2000000 -> imm sign-extended negative.
REQ-036 Stall/flush priority:
- stall=1 for 3 cycles -> pc_out unchanged.
- flush=1 with stall=1 -> valid_out=0, pc_out=0 next cycle.
REQ-037 Load-use hazard:
- ex_mem_read=1, ex_rd=2 with ADD X1,X2,X3 latched -> load_use_stall=1.
- ex_rd=31 -> load_use_stall=0.
- valid_out=0 -> load_use_stall=0.
REQ-038 Reg2 select: STUR X7,[X2,#0] (bit28=1) -> rd2 = X7 contents, not the Rm field.
